// File: rtl/can_sched_pkg.sv
// rtl/can_sched_pkg.sv - shared types and constants for the CAN TX scheduler
package can_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_ID,
    ST_LD_D0,
    ST_LD_D1,
    ST_LD_CTL,
    ST_SETTLE,
    ST_POLL,
    ST_EVAL
  } sched_state_e;

  // Core register selects
  localparam logic [1:0] RS_ID    = 2'b00;
  localparam logic [1:0] RS_DLCF  = 2'b01;
  localparam logic [1:0] RS_DATA0 = 2'b10;
  localparam logic [1:0] RS_DATA1 = 2'b11;

  // Mailbox word selects
  localparam logic [1:0] MB_ID    = 2'd0;
  localparam logic [1:0] MB_CTRL  = 2'd1;
  localparam logic [1:0] MB_DATA0 = 2'd2;
  localparam logic [1:0] MB_DATA1 = 2'd3;

  localparam int ACKF_BIT      = 11;
  localparam int BITF_BIT      = 10;
  localparam int LOSTF_BIT     = 9;
  localparam int RTS_BIT       = 8;
  localparam int TX_STROBE_BIT = 8;

  // Standard IDs are left-aligned so they compare against extended IDs on the bus order
  function automatic logic [28:0] prio_key(input logic ext, input logic [28:0] id);
    return ext ? id : {id[10:0], 18'h0};
  endfunction

endpackage

// File: rtl/can_txsched_prio.sv
// rtl/can_txsched_prio.sv - picks the pending mailbox with the smallest key, lowest index on ties
module can_txsched_prio
  import can_sched_pkg::*;
#(
  parameter int NMB = 4
) (
  input  logic [NMB-1:0]       req_i,
  input  logic [NMB-1:0][28:0] key_i,
  output logic                 valid_o,
  output logic [2:0]           idx_o
);

  logic        found;
  logic [2:0]  best_idx;
  logic [28:0] best_key;

  // Strict less-than while scanning upward keeps the lowest index on equal keys
  always_comb begin
    found    = 1'b0;
    best_idx = 3'd0;
    best_key = '1;
    for (int i = 0; i < NMB; i++) begin
      if (req_i[i] && (!found || (key_i[i] < best_key))) begin
        found    = 1'b1;
        best_idx = 3'(i);
        best_key = key_i[i];
      end
    end
  end

  assign valid_o = found;
  assign idx_o   = best_idx;

endmodule

// File: rtl/can_tx_scheduler.sv
// rtl/can_tx_scheduler.sv - multi-mailbox CAN TX scheduler owning the core register port
// Optional feature macro: CAN_TXSCHED_ABORT_EN (CTRL bit9 aborts a mailbox)
module can_tx_scheduler
  import can_sched_pkg::*;
#(
  parameter int NMB       = 4,
  parameter int RETRY_MAX = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mb_we,
  input  logic [2:0]     mb_idx,
  input  logic [1:0]     mb_word,
  input  logic [31:0]    mb_wdata,
  output logic [NMB-1:0] mb_pending,
  output logic [NMB-1:0] mb_done,
  output logic [NMB-1:0] mb_err,
  output logic           irq,
  input  logic           h_cs,
  input  logic [1:0]     h_rs,
  input  logic [3:0]     h_bytesel,
  input  logic [31:0]    h_d,
  output logic [31:0]    h_q,
  output logic           h_ready,
  output logic           c_cs,
  output logic [1:0]     c_rs,
  output logic [3:0]     c_bytesel,
  output logic [31:0]    c_d,
  input  logic [31:0]    c_q
);

  sched_state_e state_q, state_d;
  logic [2:0]   cur_idx_q, cur_idx_d;
  logic [2:0]   stat_q, stat_d;  // {ackf, bitf, lostf}

  logic [NMB-1:0][31:0] id_q, id_d, d0_q, d0_d, d1_q, d1_d;
  logic [NMB-1:0][3:0]  dlc_q, dlc_d, retry_q, retry_d;
  logic [NMB-1:0]       pend_q, pend_d, done_q, done_d, err_q, err_d;
  logic [NMB-1:0][28:0] keys;

  logic        sel_valid;
  logic [2:0]  sel_idx;
  logic        wr_valid, wr_hit_cur, abort_now, ev_abort, host_win;
  logic [31:0] cur_id, cur_d0, cur_d1, ctl_word;
  logic [3:0]  cur_dlc, cur_retry;
  logic [4:0]  retry_inc;

  assign wr_valid   = mb_we && (32'(mb_idx) < NMB);
  assign wr_hit_cur = (state_q != ST_IDLE) && (mb_idx == cur_idx_q);
  assign abort_now  = wr_valid && wr_hit_cur && (mb_word == MB_CTRL) && mb_wdata[9];

`ifdef CAN_TXSCHED_ABORT_EN
  logic abort_q, abort_d;

  // Only one frame is in flight, so a single held abort flag suffices
  assign abort_d  = (state_q == ST_EVAL) ? 1'b0 : (abort_q | abort_now);
  assign ev_abort = abort_q | abort_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_d;
    end
  end
`else
  assign ev_abort = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NMB; i++) begin
      keys[i] = prio_key(id_q[i][31], id_q[i][28:0]);
    end
  end

  can_txsched_prio #(
    .NMB (NMB)
  ) u_prio (
    .req_i   (pend_q),
    .key_i   (keys),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  always_comb begin
    cur_id    = 32'h0;
    cur_d0    = 32'h0;
    cur_d1    = 32'h0;
    cur_dlc   = 4'h0;
    cur_retry = 4'h0;
    for (int i = 0; i < NMB; i++) begin
      if (cur_idx_q == 3'(i)) begin
        cur_id    = id_q[i];
        cur_d0    = d0_q[i];
        cur_d1    = d1_q[i];
        cur_dlc   = dlc_q[i];
        cur_retry = retry_q[i];
      end
    end
  end

  assign retry_inc = {1'b0, cur_retry} + 5'd1;
  assign ctl_word  = 32'(cur_dlc) | (32'd1 << TX_STROBE_BIT);

  always_comb begin
    id_d    = id_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    dlc_d   = dlc_q;
    retry_d = retry_q;
    pend_d  = pend_q;
    done_d  = done_q;
    err_d   = err_q;

    if (state_q == ST_EVAL) begin
      for (int i = 0; i < NMB; i++) begin
        if (cur_idx_q == 3'(i)) begin
          if (stat_q[1]) begin
            err_d[i]  = 1'b1;
            pend_d[i] = 1'b0;
          end else if (stat_q[0]) begin
            if (ev_abort) begin
              err_d[i]  = 1'b1;
              pend_d[i] = 1'b0;
            end
          end else if (!stat_q[2]) begin
            if (ev_abort || (32'(retry_inc) > RETRY_MAX)) begin
              err_d[i]  = 1'b1;
              pend_d[i] = 1'b0;
            end else begin
              retry_d[i] = retry_inc[3:0];
            end
          end else begin
            done_d[i]  = 1'b1;
            pend_d[i]  = 1'b0;
            retry_d[i] = 4'h0;
          end
        end
      end
    end

    // The in-flight mailbox is frozen until its attempt has been evaluated
    if (wr_valid && !wr_hit_cur) begin
      for (int i = 0; i < NMB; i++) begin
        if (mb_idx == 3'(i)) begin
          case (mb_word)
            MB_ID:    id_d[i] = mb_wdata;
            MB_DATA0: d0_d[i] = mb_wdata;
            MB_CTRL: begin
              dlc_d[i] = mb_wdata[3:0];
              if (mb_wdata[8]) begin
                pend_d[i]  = 1'b1;
                done_d[i]  = 1'b0;
                err_d[i]   = 1'b0;
                retry_d[i] = 4'h0;
              end
`ifdef CAN_TXSCHED_ABORT_EN
              if (mb_wdata[9]) begin
                pend_d[i] = 1'b0;
                err_d[i]  = 1'b1;
              end
`endif
            end
            default:  d1_d[i] = mb_wdata;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      dlc_q   <= '0;
      retry_q <= '0;
      pend_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      id_q    <= id_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      dlc_q   <= dlc_d;
      retry_q <= retry_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // EVAL never touches the port, so the host gets it there as well
  assign host_win = h_cs && ((state_q == ST_IDLE) || (state_q == ST_SETTLE) ||
                             (state_q == ST_POLL) || (state_q == ST_EVAL));

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    stat_d    = stat_q;
    c_cs      = 1'b0;
    c_rs      = 2'b00;
    c_bytesel = 4'b0000;
    c_d       = 32'h0;
    h_ready   = 1'b1;

    if (host_win) begin
      c_cs      = 1'b1;
      c_rs      = h_rs;
      c_bytesel = h_bytesel;
      c_d       = h_d;
    end

    case (state_q)
      ST_IDLE: begin
        if (!h_cs && sel_valid && !wr_valid) begin
          cur_idx_d = sel_idx;
          state_d   = ST_LD_ID;
        end
      end
      ST_LD_ID: begin
        h_ready   = 1'b0;
        c_cs      = 1'b1;
        c_rs      = RS_ID;
        c_bytesel = 4'b1111;
        c_d       = cur_id;
        state_d   = ST_LD_D0;
      end
      ST_LD_D0: begin
        h_ready   = 1'b0;
        c_cs      = 1'b1;
        c_rs      = RS_DATA0;
        c_bytesel = 4'b1111;
        c_d       = cur_d0;
        state_d   = ST_LD_D1;
      end
      ST_LD_D1: begin
        h_ready   = 1'b0;
        c_cs      = 1'b1;
        c_rs      = RS_DATA1;
        c_bytesel = 4'b1111;
        c_d       = cur_d1;
        state_d   = ST_LD_CTL;
      end
      ST_LD_CTL: begin
        // Low two lanes only: bauddiv/irqen in the upper lanes stay untouched
        h_ready   = 1'b0;
        c_cs      = 1'b1;
        c_rs      = RS_DLCF;
        c_bytesel = 4'b0011;
        c_d       = ctl_word;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_POLL;
      end
      ST_POLL: begin
        if (!h_cs) begin
          c_cs      = 1'b1;
          c_rs      = RS_DLCF;
          c_bytesel = 4'b0000;
          if (!c_q[RTS_BIT]) begin
            stat_d  = {c_q[ACKF_BIT], c_q[BITF_BIT], c_q[LOSTF_BIT]};
            state_d = ST_EVAL;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_idx_q <= 3'd0;
      stat_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      stat_q    <= stat_d;
    end
  end

  assign mb_pending = pend_q;
  assign mb_done    = done_q;
  assign mb_err     = err_q;
  assign irq        = |(done_q | err_q);
  assign h_q        = c_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb/tb_can_tx_scheduler.sv - directed self-checking bench for can_tx_scheduler
module tb_can_tx_scheduler;

  logic        clk;
  logic        rst_n;
  logic        mb_we;
  logic [2:0]  mb_idx;
  logic [1:0]  mb_word;
  logic [31:0] mb_wdata;
  logic [3:0]  mb_pending, mb_done, mb_err;
  logic        irq;
  logic        h_cs;
  logic [1:0]  h_rs;
  logic [3:0]  h_bytesel;
  logic [31:0] h_d, h_q;
  logic        h_ready;
  logic        c_cs;
  logic [1:0]  c_rs;
  logic [3:0]  c_bytesel;
  logic [31:0] c_d, c_q;

  int passed = 0;
  int total  = 0;

  int polls_total = 0;
  int ctl_total   = 0;
  int rts_until   = 0;
  int ctl_base    = 0;
  int lost_n      = 0;
  int mode        = 0;

  logic [1:0]  wl_rs[$];
  logic [3:0]  wl_bs[$];
  logic [31:0] wl_d[$];

  can_tx_scheduler #(
    .NMB       (4),
    .RETRY_MAX (15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mb_we      (mb_we),
    .mb_idx     (mb_idx),
    .mb_word    (mb_word),
    .mb_wdata   (mb_wdata),
    .mb_pending (mb_pending),
    .mb_done    (mb_done),
    .mb_err     (mb_err),
    .irq        (irq),
    .h_cs       (h_cs),
    .h_rs       (h_rs),
    .h_bytesel  (h_bytesel),
    .h_d        (h_d),
    .h_q        (h_q),
    .h_ready    (h_ready),
    .c_cs       (c_cs),
    .c_rs       (c_rs),
    .c_bytesel  (c_bytesel),
    .c_d        (c_d),
    .c_q        (c_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: rts held for a number of scheduler polls, then a mode-dependent status
  always_comb begin
    if (polls_total < rts_until) c_q = 32'h0000_0100;
    else begin
      case (mode)
        0:       c_q = 32'h0000_0800;
        1:       c_q = 32'h0000_0000;
        2:       c_q = ((ctl_total - ctl_base) <= lost_n) ? 32'h0000_0200 : 32'h0000_0800;
        default: c_q = 32'h0000_0400;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_n && c_cs && !h_cs) begin
      if (c_rs == 2'b01 && c_bytesel == 4'b0000) polls_total <= polls_total + 1;
      if (c_rs == 2'b01 && c_bytesel == 4'b0011) ctl_total <= ctl_total + 1;
    end
    if (rst_n && c_cs && c_bytesel != 4'b0000) begin
      wl_rs.push_back(c_rs);
      wl_bs.push_back(c_bytesel);
      wl_d.push_back(c_d);
    end
  end

  task automatic mb_wr(input logic [2:0] idx, input logic [1:0] word, input logic [31:0] data);
    mb_we    = 1'b1;
    mb_idx   = idx;
    mb_word  = word;
    mb_wdata = data;
    @(posedge clk);
    #1;
    mb_we = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mb_pending == 4'b0000) break;
    end
    if (mb_pending !== 4'b0000) $display("FAIL %s_timeout: pending=%b required 0000", tag, mb_pending);
    else passed++;
    total++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mb_we = 1'b0; mb_idx = 3'd0; mb_word = 2'd0; mb_wdata = 32'h0;
    h_cs = 1'b0; h_rs = 2'd0; h_bytesel = 4'h0; h_d = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    if (mb_pending !== 4'b0) $display("FAIL rst_pending: got %b required 0000", mb_pending); else passed++; total++;
    if (mb_done !== 4'b0) $display("FAIL rst_done: got %b required 0000", mb_done); else passed++; total++;
    if (mb_err !== 4'b0) $display("FAIL rst_err: got %b required 0000", mb_err); else passed++; total++;
    if (irq !== 1'b0) $display("FAIL rst_irq: got %b required 0", irq); else passed++; total++;
    if (c_cs !== 1'b0) $display("FAIL rst_c_cs: got %b required 0", c_cs); else passed++; total++;
    if (c_bytesel !== 4'b0) $display("FAIL rst_c_bytesel: got %b required 0000", c_bytesel); else passed++; total++;
    if (c_d !== 32'h0) $display("FAIL rst_c_d: got %h required 0", c_d); else passed++; total++;
    if (h_ready !== 1'b1) $display("FAIL rst_h_ready: got %b required 1", h_ready); else passed++; total++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    h_d = 32'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bad_index;
    int cb;
    cb = ctl_total;
    mb_wr(3'd5, 2'd1, 32'h0000_0100);
    repeat (6) @(negedge clk);
    if (mb_pending !== 4'b0 || ctl_total != cb)
      $display("FAIL bad_idx: pending=%b attempts=%0d required 0000 and 0", mb_pending, ctl_total - cb);
    else passed++;
    total++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    int base, pb;
    logic [1:0]  ers[4];
    logic [3:0]  ebs[4];
    logic [31:0] ed[4];
    ers = '{2'd0, 2'd2, 2'd3, 2'd1};
    ebs = '{4'hF, 4'hF, 4'hF, 4'h3};
    ed  = '{32'h0000_0123, 32'h1122_3344, 32'h5566_7788, 32'h0000_0102};
    mode = 0;
    rts_until = polls_total + 5;
    pb = polls_total;
    base = wl_d.size();
    mb_wr(3'd2, 2'd0, 32'h0000_0123);
    mb_wr(3'd2, 2'd2, 32'h1122_3344);
    mb_wr(3'd2, 2'd3, 32'h5566_7788);
    mb_wr(3'd2, 2'd1, 32'h0000_0102);
    wait_idle(200, "single");
    if (wl_d.size() - base != 4) $display("FAIL single_nwrites: got %0d required 4", wl_d.size() - base);
    else passed++;
    total++;
    if (wl_d.size() - base >= 4) begin
      for (int k = 0; k < 4; k++) begin
        if (wl_rs[base+k] !== ers[k] || wl_bs[base+k] !== ebs[k] || wl_d[base+k] !== ed[k])
          $display("FAIL single_write%0d: got rs=%0d bs=%h d=%h required rs=%0d bs=%h d=%h",
                   k, wl_rs[base+k], wl_bs[base+k], wl_d[base+k], ers[k], ebs[k], ed[k]);
        else passed++;
        total++;
      end
    end
    if (polls_total - pb != 6) $display("FAIL single_polls: got %0d required 6", polls_total - pb); else passed++; total++;
    if (mb_done !== 4'b0100) $display("FAIL single_done: got %b required 0100", mb_done); else passed++; total++;
    if (mb_err !== 4'b0000) $display("FAIL single_err: got %b required 0000", mb_err); else passed++; total++;
    if (irq !== 1'b1) $display("FAIL single_irq: got %b required 1", irq); else passed++; total++;
  endtask

  task automatic test_priority;
    int base;
    mode = 0;
    rts_until = polls_total;
    mb_wr(3'd0, 2'd0, 32'h0000_0400);
    mb_wr(3'd3, 2'd0, 32'h0000_0100);
    base = wl_d.size();
    mb_wr(3'd0, 2'd1, 32'h0000_0100);
    mb_wr(3'd3, 2'd1, 32'h0000_0100);
    wait_idle(200, "prio");
    if (wl_d.size() - base != 8) $display("FAIL prio_nwrites: got %0d required 8", wl_d.size() - base);
    else passed++;
    total++;
    if (wl_d.size() - base >= 8) begin
      if (wl_d[base] !== 32'h100) $display("FAIL prio_first: got %h required 00000100", wl_d[base]); else passed++;
      total++;
      if (wl_d[base+4] !== 32'h400) $display("FAIL prio_second: got %h required 00000400", wl_d[base+4]); else passed++;
      total++;
    end
    if (mb_done !== 4'b1101) $display("FAIL prio_done: got %b required 1101", mb_done); else passed++; total++;
  endtask

  task automatic test_retry_exhaust;
    mode = 1;
    rts_until = polls_total;
    ctl_base = ctl_total;
    mb_wr(3'd1, 2'd0, 32'h0000_0050);
    mb_wr(3'd1, 2'd1, 32'h0000_0100);
    wait_idle(1000, "retry");
    if (ctl_total - ctl_base != 16) $display("FAIL retry_attempts: got %0d required 16", ctl_total - ctl_base); else passed++; total++;
    if (mb_err !== 4'b0010) $display("FAIL retry_err: got %b required 0010", mb_err); else passed++; total++;
    if (mb_done[1] !== 1'b0) $display("FAIL retry_done: got %b required 0", mb_done[1]); else passed++; total++;
  endtask

  task automatic test_lost;
    mode = 2;
    lost_n = 20;
    rts_until = polls_total;
    ctl_base = ctl_total;
    mb_wr(3'd2, 2'd1, 32'h0000_0102);
    if (mb_done[2] !== 1'b0) $display("FAIL lost_done_clr: got %b required 0", mb_done[2]); else passed++; total++;
    wait_idle(1000, "lost");
    if (ctl_total - ctl_base != 21) $display("FAIL lost_attempts: got %0d required 21", ctl_total - ctl_base); else passed++; total++;
    if (mb_done[2] !== 1'b1) $display("FAIL lost_done: got %b required 1", mb_done[2]); else passed++; total++;
    if (mb_err[2] !== 1'b0) $display("FAIL lost_err: got %b required 0", mb_err[2]); else passed++; total++;
  endtask

  task automatic test_bitf;
    mode = 3;
    rts_until = polls_total;
    ctl_base = ctl_total;
    mb_wr(3'd3, 2'd1, 32'h0000_0100);
    wait_idle(200, "bitf");
    if (ctl_total - ctl_base != 1) $display("FAIL bitf_attempts: got %0d required 1", ctl_total - ctl_base); else passed++; total++;
    if (mb_err[3] !== 1'b1 || mb_done[3] !== 1'b0)
      $display("FAIL bitf_flags: got err=%b done=%b required err=1 done=0", mb_err[3], mb_done[3]);
    else passed++;
    total++;
  endtask

  task automatic test_host;
    int stall, pb;
    mode = 0;
    rts_until = polls_total + 3;
    mb_wr(3'd0, 2'd1, 32'h0000_0100);
    @(posedge clk);
    @(posedge clk);
    #1;
    h_cs = 1'b1; h_rs = 2'b01; h_bytesel = 4'b0000; h_d = 32'h0;
    stall = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (h_ready) break;
      stall++;
    end
    if (stall != 3) $display("FAIL host_ld_stall: got %0d cycles required 3", stall); else passed++; total++;
    if (h_ready !== 1'b1 || c_cs !== 1'b1 || c_rs !== 2'b01 || c_bytesel !== 4'b0000)
      $display("FAIL host_ld_grant: got ready=%b cs=%b rs=%0d bs=%h required 1 1 1 0", h_ready, c_cs, c_rs, c_bytesel);
    else passed++;
    total++;
    if (h_q !== 32'h0000_0100) $display("FAIL host_ld_q: got %h required 00000100", h_q); else passed++; total++;
    @(posedge clk);
    #1 h_cs = 1'b0;
    @(posedge clk);
    #1;
    h_cs = 1'b1; h_rs = 2'b10; h_bytesel = 4'b0000;
    pb = polls_total;
    @(negedge clk);
    if (h_ready !== 1'b1 || c_rs !== 2'b10 || c_bytesel !== 4'b0000)
      $display("FAIL host_poll_grant: got ready=%b rs=%0d bs=%h required 1 2 0", h_ready, c_rs, c_bytesel);
    else passed++;
    total++;
    @(posedge clk);
    #1 h_cs = 1'b0;
    if (polls_total != pb) $display("FAIL host_poll_skip: got %0d polls required 0", polls_total - pb); else passed++; total++;
    wait_idle(200, "host");
    if (mb_done[0] !== 1'b1) $display("FAIL host_done: got %b required 1", mb_done[0]); else passed++; total++;
  endtask

  task automatic test_abort;
    int pb;
    mode = 1;
    rts_until = polls_total + 4;
    pb = polls_total;
    ctl_base = ctl_total;
    mb_wr(3'd1, 2'd1, 32'h0000_0100);
    if (mb_err[1] !== 1'b0) $display("FAIL abort_err_clr: got %b required 0", mb_err[1]); else passed++; total++;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (polls_total > pb) break;
    end
    mb_wr(3'd1, 2'd1, 32'h0000_0200);
    wait_idle(1000, "abort");
`ifdef CAN_TXSCHED_ABORT_EN
    if (ctl_total - ctl_base != 1) $display("FAIL abort_attempts: got %0d required 1", ctl_total - ctl_base); else passed++; total++;
`else
    if (ctl_total - ctl_base != 16) $display("FAIL abort_attempts: got %0d required 16", ctl_total - ctl_base); else passed++; total++;
`endif
    if (mb_err[1] !== 1'b1) $display("FAIL abort_err: got %b required 1", mb_err[1]); else passed++; total++;
  endtask

  initial begin
    test_reset();
    test_bad_index();
    test_single();
    test_priority();
    test_retry_exhaust();
    test_lost();
    test_bitf();
    test_host();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
